// File: rtl/ppg_controller.sv
// Pulse-oximeter front-end controller: IR/RED LED multiplexing, ADC sampling, AFE calibration and filtering.
// Build option PPG_FIR_EN: when defined, per-channel 16-tap FIR filters; otherwise raw samples pass through per frame.
module ppg_controller #(
    parameter logic [7:0] ADC_LO         = 8'd64,
    parameter logic [7:0] ADC_HI         = 8'd192,
    parameter logic [6:0] DC_INIT        = 7'd64,
    parameter logic [3:0] LED_DRIVE_INIT = 4'd8
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [7:0]  ADC,
    input  logic        Find_setting,
    output logic [3:0]  LED_DRIVE,
    output logic [6:0]  DC_Comp,
    output logic        LED_IR,
    output logic        LED_RED,
    output logic [3:0]  PGA_Gain,
    output logic        CLK_Filter,
    output logic [7:0]  IR_ADC_Value,
    output logic [7:0]  RED_ADC_Value,
    output logic [19:0] Out_IR_Filtered,
    output logic [19:0] Out_RED_Filtered
);

    typedef enum logic [1:0] {RUN, CAL_DC, CAL_GAIN} state_t;

    state_t     state, state_d;
    logic [3:0] cnt;
    logic [6:0] dc_d;
    logic [3:0] gain_d;
    logic       ir_slot_end, frame_end, in_window;

    assign ir_slot_end = (cnt == 4'd3);
    assign frame_end   = (cnt == 4'd9);
    assign in_window   = (ADC >= ADC_LO) && (ADC <= ADC_HI);

    // NOTE: sequential state uses <= so every register sees the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (rst) cnt <= 4'd0;
        else     cnt <= frame_end ? 4'd0 : cnt + 4'd1;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= RUN;
            DC_Comp   <= DC_INIT;
            PGA_Gain  <= 4'd0;
            LED_DRIVE <= LED_DRIVE_INIT;
        end else begin
            state    <= state_d;
            DC_Comp  <= dc_d;
            PGA_Gain <= gain_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        dc_d    = DC_Comp;
        gain_d  = PGA_Gain;
        if (Find_setting) begin
            state_d = CAL_DC;
            dc_d    = DC_INIT;
            gain_d  = 4'd0;
        end else if (ir_slot_end) begin
            // Decisions use the sample being captured at this very edge.
            case (state)
                CAL_DC: begin
                    if (ADC > ADC_HI) begin
                        if (DC_Comp == 7'd127) state_d = CAL_GAIN;
                        else                   dc_d    = DC_Comp + 7'd1;
                    end else if (ADC < ADC_LO) begin
                        if (DC_Comp == 7'd0) state_d = CAL_GAIN;
                        else                 dc_d    = DC_Comp - 7'd1;
                    end else begin
                        state_d = CAL_GAIN;
                    end
                end
                CAL_GAIN: begin
                    if (in_window) begin
                        if (PGA_Gain == 4'd15) state_d = RUN;
                        else                   gain_d  = PGA_Gain + 4'd1;
                    end else begin
                        state_d = RUN;
                        if (PGA_Gain != 4'd0) gain_d = PGA_Gain - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        LED_IR     = 1'b0;
        LED_RED    = 1'b0;
        CLK_Filter = 1'b0;
        if (!rst) begin
            LED_IR     = (cnt <= 4'd3);
            LED_RED    = (cnt >= 4'd5) && (cnt <= 4'd8);
            CLK_Filter = frame_end;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            IR_ADC_Value  <= 8'd0;
            RED_ADC_Value <= 8'd0;
        end else begin
            if (ir_slot_end)   IR_ADC_Value  <= ADC;
            if (cnt == 4'd8)   RED_ADC_Value <= ADC;
        end
    end

`ifdef PPG_FIR_EN
    localparam logic [4:0] COEF [16] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24,
                                         5'd24, 5'd20, 5'd16, 5'd12, 5'd8, 5'd4, 5'd2, 5'd1};

    logic [7:0] ir_taps  [16];
    logic [7:0] red_taps [16];

    // Output for the line after shifting in newest: taps[k-1] becomes tap k.
    function automatic logic [19:0] fir_sum(input logic [7:0] newest, input logic [7:0] taps [16]);
        logic [19:0] acc;
        acc = 20'(COEF[0]) * 20'(newest);
        for (int k = 1; k < 16; k++) acc = acc + 20'(COEF[k]) * 20'(taps[k-1]);
        return acc;
    endfunction

    // NOTE: the delay lines are small flop arrays, not RAM, so they take a reset like any register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                ir_taps[k]  <= 8'd0;
                red_taps[k] <= 8'd0;
            end
            Out_IR_Filtered  <= 20'd0;
            Out_RED_Filtered <= 20'd0;
        end else if (frame_end) begin
            ir_taps[0]  <= IR_ADC_Value;
            red_taps[0] <= RED_ADC_Value;
            for (int k = 1; k < 16; k++) begin
                ir_taps[k]  <= ir_taps[k-1];
                red_taps[k] <= red_taps[k-1];
            end
            Out_IR_Filtered  <= fir_sum(IR_ADC_Value, ir_taps);
            Out_RED_Filtered <= fir_sum(RED_ADC_Value, red_taps);
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (rst) begin
            Out_IR_Filtered  <= 20'd0;
            Out_RED_Filtered <= 20'd0;
        end else if (frame_end) begin
            Out_IR_Filtered  <= {12'b0, IR_ADC_Value};
            Out_RED_Filtered <= {12'b0, RED_ADC_Value};
        end
    end
`endif

endmodule

// File: tb/tb_ppg_controller.sv
// Self-checking bench for ppg_controller: directed calibration/filter scenarios plus random traffic
// compared every cycle against a frame-level behavioural model (honours PPG_FIR_EN like the design).
module tb_ppg_controller;

    localparam int COEF [16] = '{1, 2, 4, 8, 12, 16, 20, 24, 24, 20, 16, 12, 8, 4, 2, 1};
    localparam int MODE_RUN = 0, MODE_DC = 1, MODE_GAIN = 2;

    logic        CLK = 1'b0;
    logic        rst;
    logic [7:0]  ADC;
    logic        Find_setting;
    logic [3:0]  LED_DRIVE;
    logic [6:0]  DC_Comp;
    logic        LED_IR, LED_RED;
    logic [3:0]  PGA_Gain;
    logic        CLK_Filter;
    logic [7:0]  IR_ADC_Value, RED_ADC_Value;
    logic [19:0] Out_IR_Filtered, Out_RED_Filtered;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: frame position, calibration mode, codes, samples, filter history.
    int m_cnt = 0, m_mode = MODE_RUN, m_dc = 64, m_gain = 0;
    int m_ir = 0, m_red = 0, m_out_ir = 0, m_out_red = 0;
    int ir_hist[$];
    int red_hist[$];

    ppg_controller dut (
        .CLK              (CLK),
        .rst              (rst),
        .ADC              (ADC),
        .Find_setting     (Find_setting),
        .LED_DRIVE        (LED_DRIVE),
        .DC_Comp          (DC_Comp),
        .LED_IR           (LED_IR),
        .LED_RED          (LED_RED),
        .PGA_Gain         (PGA_Gain),
        .CLK_Filter       (CLK_Filter),
        .IR_ADC_Value     (IR_ADC_Value),
        .RED_ADC_Value    (RED_ADC_Value),
        .Out_IR_Filtered  (Out_IR_Filtered),
        .Out_RED_Filtered (Out_RED_Filtered)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fir_model(input int hist[$]);
        int acc = 0;
        for (int i = 0; i < hist.size(); i++) acc += COEF[i] * hist[i];
        return acc;
    endfunction

    task automatic calibrate(input int s);
        bit inside_win = (s >= 64) && (s <= 192);
        if (m_mode == MODE_DC) begin
            if (s > 192)     begin if (m_dc < 127) m_dc++; else m_mode = MODE_GAIN; end
            else if (s < 64) begin if (m_dc > 0)   m_dc--; else m_mode = MODE_GAIN; end
            else m_mode = MODE_GAIN;
        end else if (m_mode == MODE_GAIN) begin
            if (inside_win && m_gain < 15) m_gain++;
            else if (inside_win)           m_mode = MODE_RUN;
            else begin
                if (m_gain > 0) m_gain--;
                m_mode = MODE_RUN;
            end
        end
    endtask

    // Advance the model by one rising edge using the inputs presented at that edge.
    task automatic model_edge();
        int pos = m_cnt;
        if (rst) begin
            m_cnt = 0; m_mode = MODE_RUN; m_dc = 64; m_gain = 0;
            m_ir = 0; m_red = 0; m_out_ir = 0; m_out_red = 0;
            ir_hist.delete(); red_hist.delete();
        end else begin
            if (Find_setting) begin
                m_mode = MODE_DC; m_dc = 64; m_gain = 0;
            end else if (pos == 3) begin
                calibrate(int'(ADC));
            end
            if (pos == 3) m_ir  = int'(ADC);
            if (pos == 8) m_red = int'(ADC);
            if (pos == 9) begin
`ifdef PPG_FIR_EN
                ir_hist.push_front(m_ir);
                red_hist.push_front(m_red);
                if (ir_hist.size() > 16)  void'(ir_hist.pop_back());
                if (red_hist.size() > 16) void'(red_hist.pop_back());
                m_out_ir  = fir_model(ir_hist);
                m_out_red = fir_model(red_hist);
`else
                m_out_ir  = m_ir;
                m_out_red = m_red;
`endif
            end
            m_cnt = (m_cnt + 1) % 10;
        end
    endtask

    task automatic compare_all();
        check("led_ir",     LED_IR,     (!rst && m_cnt <= 3));
        check("led_red",    LED_RED,    (!rst && m_cnt >= 5 && m_cnt <= 8));
        check("clk_filter", CLK_Filter, (!rst && m_cnt == 9));
        check("led_drive",  LED_DRIVE,  8);
        check("dc_comp",    DC_Comp,    m_dc);
        check("pga_gain",   PGA_Gain,   m_gain);
        check("ir_sample",  IR_ADC_Value,  m_ir);
        check("red_sample", RED_ADC_Value, m_red);
        check("out_ir",     Out_IR_Filtered,  m_out_ir);
        check("out_red",    Out_RED_Filtered, m_out_red);
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_find();
        Find_setting = 1'b1;
        step();
        Find_setting = 1'b0;
    endtask

    task automatic wait_gain(input int target);
        for (int i = 0; i < 400 && m_gain != target; i++) step();
    endtask

    task automatic run_frame(input logic [7:0] ir_v, input logic [7:0] red_v);
        for (int i = 0; i < 10; i++) begin
            ADC = (m_cnt <= 4) ? ir_v : red_v;
            step();
        end
    endtask

    initial begin
        int exp_v;
        rst = 1'b1; Find_setting = 1'b0; ADC = 8'd0;

        // Reset held for two cycles.
        run_cycles(2);
        check("reset_dc",    DC_Comp, 64);
        check("reset_gain",  PGA_Gain, 0);
        check("reset_drive", LED_DRIVE, 8);
        check("reset_strobes", {LED_IR, LED_RED, CLK_Filter}, 0);
        check("reset_out_ir",  Out_IR_Filtered, 0);
        check("reset_out_red", Out_RED_Filtered, 0);
        rst = 1'b0;

        // First frame: slot timing and sampling.
        for (int i = 0; i < 10; i++) begin
            ADC = (m_cnt <= 4) ? 8'h11 : 8'h22;
            step();
            check("frame_led_ir",  LED_IR,  ((i + 1) % 10) < 4);
            check("frame_led_red", LED_RED, ((i + 1) % 10) >= 5 && ((i + 1) % 10) <= 8);
            check("frame_strobe",  CLK_Filter, i == 8);
        end
        check("ir_sample_11",  IR_ADC_Value, 8'h11);
        check("red_sample_22", RED_ADC_Value, 8'h22);

        // DC calibration climbing one step per frame, then hand-off to gain.
        ADC = 8'd230;
        pulse_find();
        run_cycles(50);
        check("dc_climb_69", DC_Comp, 69);
        ADC = 8'd150;
        run_cycles(10);
        check("dc_frozen", DC_Comp, 69);
        run_cycles(10);
        check("gain_started", PGA_Gain, 1);
        run_cycles(160);
        check("gain_top_after_dc", PGA_Gain, 15);

        // Full gain ramp to 15 and hold in RUN.
        ADC = 8'd128;
        pulse_find();
        run_cycles(200);
        check("ramp_dc_64", DC_Comp, 64);
        check("ramp_gain_15", PGA_Gain, 15);
        ADC = 8'd250;
        run_cycles(20);
        check("run_holds_gain", PGA_Gain, 15);

        // Out-of-window sample during ramp backs gain off by one and ends calibration.
        ADC = 8'd128;
        pulse_find();
        wait_gain(6);
        check("reach_gain_6", PGA_Gain, 6);
        ADC = 8'd250;
        run_cycles(10);
        ADC = 8'd128;
        run_cycles(30);
        check("backoff_gain_5", PGA_Gain, 5);

        // Restart in the middle of a gain ramp.
        pulse_find();
        wait_gain(7);
        check("reach_gain_7", PGA_Gain, 7);
        ADC = 8'd40;
        pulse_find();
        check("restart_gain_0", PGA_Gain, 0);
        check("restart_dc_64",  DC_Comp, 64);
        run_cycles(20);
        check("restart_in_dc_cal", DC_Comp, 62);

        // Saturation at both ends of DC_Comp.
        ADC = 8'd255;
        pulse_find();
        run_cycles(700);
        check("dc_sat_127", DC_Comp, 127);
        check("dc_sat_hi_gain", PGA_Gain, 0);
        ADC = 8'd0;
        pulse_find();
        run_cycles(700);
        check("dc_sat_0", DC_Comp, 0);
        check("dc_sat_lo_gain", PGA_Gain, 0);

        // Random traffic with occasional calibration requests and resets.
        for (int i = 0; i < 600; i++) begin
            ADC          = 8'($urandom_range(0, 255));
            Find_setting = ($urandom_range(0, 19) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; Find_setting = 1'b0;

        // Impulse response, then full-scale step response.
        for (int i = 0; i < 10 && m_cnt != 0; i++) step();
        for (int f = 0; f < 17; f++) run_frame(8'd0, 8'd0);
        run_frame(8'd1, 8'd0);
`ifdef PPG_FIR_EN
        exp_v = 1;
`else
        exp_v = 1;
`endif
        check("impulse_tap0", Out_IR_Filtered, exp_v);
        for (int k = 1; k <= 16; k++) begin
            run_frame(8'd0, 8'd0);
`ifdef PPG_FIR_EN
            exp_v = (k < 16) ? COEF[k] : 0;
`else
            exp_v = 0;
`endif
            check("impulse_tap", Out_IR_Filtered, exp_v);
        end
        for (int f = 0; f < 17; f++) run_frame(8'd255, 8'd255);
`ifdef PPG_FIR_EN
        exp_v = 44370;
`else
        exp_v = 255;
`endif
        check("fullscale_ir",  Out_IR_Filtered, exp_v);
        check("fullscale_red", Out_RED_Filtered, exp_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppg_controller.md
Name: ppg_controller

Overview:
- Front-end controller for a two-wavelength (IR/RED) pulse-oximeter finger clip.
- Time-multiplexes the IR and RED LEDs and samples the 8-bit ADC in each LED slot.
- On request, calibrates the analog front end: DC compensation first, then PGA gain.
- Feeds each channel's samples into its own identical 16-tap FIR low-pass filter and presents the filtered 20-bit results.

Parameters:
- ADC_LO, 64: lower bound of the acceptable IR sample window.
- ADC_HI, 192: upper bound of the acceptable IR sample window.
- DC_INIT, 64: DC_Comp value after reset and at calibration start.
- LED_DRIVE_INIT, 8: constant LED drive current code.

Ports:
- CLK  in  1  system clock (nominal 1 kHz).
- rst  in  1  synchronous reset, active-high.
- ADC  in  8  front-end ADC sample, unsigned.
- Find_setting  in  1  calibration request, level-sampled on CLK.
- LED_DRIVE  out  4  LED current code.
- DC_Comp  out  7  DC compensation DAC code.
- LED_IR  out  1  IR LED enable.
- LED_RED  out  1  RED LED enable.
- PGA_Gain  out  4  PGA gain code.
- CLK_Filter  out  1  one-cycle filter strobe, once per frame.
- IR_ADC_Value  out  8  latest IR sample.
- RED_ADC_Value  out  8  latest RED sample.
- Out_IR_Filtered  out  20  IR FIR output.
- Out_RED_Filtered  out  20  RED FIR output.

Behaviour:
- Single clock domain; every register updates on rising CLK.
- rst=1 at an edge sets every register to its reset value:
  - cnt=0, state=RUN, DC_Comp=DC_INIT, PGA_Gain=0, LED_DRIVE=LED_DRIVE_INIT.
  - Sample registers, filter delay lines and filter outputs = 0.
- Frame counter cnt runs 0..9 then wraps to 0; it runs in all states.
- Decoded outputs (from the registered cnt):
  - LED_IR=1 for cnt 0..3.
  - LED_RED=1 for cnt 5..8.
  - CLK_Filter=1 for cnt 9.
  - All three are 0 during reset.
- IR sample: at the edge ending cnt=3, IR_ADC_Value<=ADC.
- RED sample: at the edge ending cnt=8, RED_ADC_Value<=ADC.
- States: RUN, CAL_DC, CAL_GAIN.
- Find_setting=1 at any edge while not in reset:
  - state<=CAL_DC, DC_Comp<=DC_INIT, PGA_Gain<=0.
  - Takes priority over every other calibration action, so it restarts a calibration already in progress.
- Calibration decisions happen only at the IR-sample edge, using the ADC value captured at that edge (s).
- CAL_DC:
  - If s>ADC_HI: DC_Comp+1, saturating at 127.
  - Else if s<ADC_LO: DC_Comp-1, saturating at 0.
  - Else: go to CAL_GAIN.
  - If the required step is blocked by saturation: go to CAL_GAIN anyway.
- CAL_GAIN:
  - If s is within [ADC_LO, ADC_HI] and PGA_Gain<15: PGA_Gain+1.
  - If s is within the window and PGA_Gain==15: go to RUN.
  - If s is outside the window: PGA_Gain-1 (saturating at 0), then go to RUN.
- RUN: DC_Comp and PGA_Gain hold.
- LED_DRIVE stays constant at LED_DRIVE_INIT.
- FIR filters: one per channel, identical, each with a 16-entry 8-bit delay line.
  - On the edge where CLK_Filter=1, the delay line shifts in the channel's current sample register.
  - In the same edge, Out <= sum over k=0..15 of c[k]*x[k], where x[0] is the newly shifted sample.
  - Output latency: valid one cycle after the strobe; holds for the rest of the frame.
  - Coefficients c[0..15] = 1,2,4,8,12,16,20,24,24,20,16,12,8,4,2,1 (sum 174).
  - Arithmetic is unsigned. Maximum result 255*174=44370, so no overflow; the result is zero-extended to 20 bits.
- The filters run continuously during calibration; the delay lines are not flushed.

Optional Feature:
- Macro PPG_FIR_EN.
- Defined: the FIR filters behave as specified above.
- Undefined:
  - No filter logic is built.
  - On the CLK_Filter edge, Out_IR_Filtered<={12'b0, IR_ADC_Value} and Out_RED_Filtered<={12'b0, RED_ADC_Value}.
  - Reset value 0; timing otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release.
  - During reset: DC_Comp=64, PGA_Gain=0, LED_DRIVE=8, all LEDs/CLK_Filter=0, filtered outputs=0.
  - After release: LED_IR is high for the first 4 cycles and LED_RED for cycles 5..8; CLK_Filter pulses every 10th cycle.
- Sampling: ADC=0x11 during cnt 0..4 and 0x22 during cnt 5..9.
  - IR_ADC_Value=0x11 from cnt 4.
  - RED_ADC_Value=0x22 from cnt 9.
- DC calibration: pulse Find_setting with ADC constant 230.
  - DC_Comp steps 64->65->66... at one step per frame.
  - When ADC switches to 150: state moves to CAL_GAIN with DC_Comp frozen.
- Gain ramp: ADC held at 128 after calibration starts.
  - DC_Comp stays 64; PGA_Gain increments once per frame to 15, then RUN.
  - Repeat with ADC forced to 250 when PGA_Gain=6: PGA_Gain settles at 5 in RUN.
- Restart: assert Find_setting while PGA_Gain=7 in CAL_GAIN -> next edge shows PGA_Gain=0, DC_Comp=64, state=CAL_DC.
- Impulse (PPG_FIR_EN defined): IR sample 1 for one frame, then 0.
  - Out_IR_Filtered takes 1,2,4,8,12,...,2,1 on successive frames, then 0.
  - Constant 255 for 16+ frames gives 44370.
